// File: rtl/arith_seq_if.sv
// arith_seq_if: request/result handshake bundle between a requester and arith_seq.
interface arith_seq_if #(parameter int WIDTH = 4);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] res;
    logic [5:0]         flags;
    logic [1:0]         err;
    modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, res, flags, err);
    modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, res, flags, err);
endinterface

// File: rtl/arith_seq.sv
// arith_seq: registered arithmetic/compare unit with an iterative restoring divider.
// Define ARITH_SEQ_REM_EN to return the division remainder in the upper result half.
module arith_seq #(
    parameter int WIDTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    arith_seq_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
`ifdef ARITH_SEQ_REM_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [W2-1:0]    res_q, res_d;
    logic [5:0]       flags_q, flags_d;
    logic [1:0]       err_q, err_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_nx, quo_nx, bz_hi, div_hi;
    logic [W2-1:0]    ax, bx, alu;
    logic             fits;

    function automatic logic [5:0] flags_of(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return {x > y, x >= y, x <= y, x < y, x != y, x == y};
    endfunction

    always_comb begin
        ax     = W2'(bus.a);
        bx     = W2'(bus.b);
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        fits   = rem_sh >= {1'b0, b_q};
        rem_nx = fits ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], fits};
        bz_hi  = REM_EN ? bus.a : {WIDTH{1'b0}};
        div_hi = REM_EN ? rem_nx : {WIDTH{1'b0}};
        case (bus.op)
            4'd0:    alu = W2'(|bus.a && |bus.b);
            4'd1:    alu = W2'(|bus.a || |bus.b);
            4'd2:    alu = ax & bx;
            4'd3:    alu = ax | bx;
            4'd4:    alu = ax ^ bx;
            4'd5:    alu = ax + bx;
            4'd6:    alu = ax - bx;
            4'd7:    alu = ax * bx;
            4'd8:    alu = {bz_hi, {WIDTH{1'b1}}};  // only reached on divide-by-zero
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = err_q;
        if (state_q == IDLE && bus.in_valid) begin
            a_d   = bus.a;
            b_d   = bus.b;
            quo_d = bus.a;
            rem_d = '0;
            cnt_d = '0;
            if (bus.op == 4'd8 && bus.b != '0) begin
                state_d = DIV;
            end else begin
                state_d = DONE;
                res_d   = alu;
                flags_d = flags_of(bus.a, bus.b);
                err_d   = {bus.op > 4'd9, bus.op == 4'd8 && bus.b == '0};
            end
        end else if (state_q == DIV) begin
            quo_d = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(WIDTH - 1)) begin
                state_d = DONE;
                res_d   = {div_hi, quo_nx};
                flags_d = flags_of(a_q, b_q);
                err_d   = '0;
            end
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.res       = res_q;
    assign bus.flags     = flags_q;
    assign bus.err       = err_q;
endmodule

// File: doc/arith_seq.md
Name: arith_seq

Overview:
- Parametrised, registered successor to the team's combinational 4-bit arithmetic/compare block.
- Single operation unit for datapath control logic: accepts one operation per valid/ready transaction, returns a 2*WIDTH result plus compare flags.
- Adds op selection, output backpressure and an iterative multi-cycle divider in place of a combinational one.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..32).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request.
- op  in  4  opcode. 0 logical-and, 1 logical-or, 2 and, 3 or, 4 xor, 5 add, 6 sub, 7 mul, 8 div, 9 compare, 10-15 illegal.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- res  out  2*WIDTH  result.
- flags  out  6  compare flags {gt,ge,le,lt,ne,eq}, MSB first.
- err  out  2  {illegal_op, div_by_zero}.

Behaviour:
- Reset values: in_ready=1 (after deassertion), out_valid=0, res=0, flags=0, err=0, FSM=IDLE.
- Reset is asynchronous and takes effect mid-operation. Any in-flight division and any pending result are discarded; no out_valid follows.
- FSM states: IDLE, DIV, DONE. in_ready=1 only in IDLE. No overlap: exactly one operation in flight at a time.
- Accept = in_valid & in_ready. a, b and op are captured on accept.
- Non-div ops: IDLE -> DONE on accept. out_valid rises on the next edge (latency 1).
- div with b!=0: IDLE -> DIV. Radix-2 restoring divider, one quotient bit per cycle, WIDTH cycles. DIV -> DONE, so out_valid is asserted WIDTH+1 edges after accept.
- div with b==0: IDLE -> DONE directly (latency 1). Quotient = all ones (WIDTH bits), err[0]=1.
- DONE: res/flags/err held stable while out_valid & !out_ready. When out_valid & out_ready: DONE -> IDLE, out_valid=0, res/flags/err keep their last value.
- A new request is accepted no earlier than the cycle after the result handshake.
- Width rules; all results are zero-extended to 2*WIDTH unless noted:
  - ops 0/1: res[0] = (a!=0) AND/OR (b!=0), other bits 0.
  - ops 2-4: bitwise.
  - op 5: WIDTH+1-bit sum.
  - op 6: (a - b) mod 2^(2*WIDTH), i.e. a borrow sets all upper bits.
  - op 7: full 2*WIDTH product.
  - op 8: quotient in res[WIDTH-1:0]; upper half per the optional feature.
- flags: valid with every result regardless of op. Computed from the captured a and b.
- Illegal op: latency 1, res=0, flags computed, err[1]=1.
- in_valid while busy is ignored. The requester must hold its request until in_ready.

Optional Feature:
- ARITH_SEQ_REM_EN defined: for op 8, res[2*WIDTH-1:WIDTH] = remainder. On divide-by-zero the remainder = a.
- ARITH_SEQ_REM_EN undefined: upper half is 0 for op 8, and no remainder register is kept beyond the divider's working register.

Test Plan (WIDTH=4):
- add a=9,b=8: one edge after accept, out_valid=1, res=0x11, flags=gt,ge,ne (0b110010), err=0.
- sub a=3,b=5 -> res=0xFE. mul a=15,b=15 -> res=0xE1. compare a=3,b=5 -> flags=le,lt,ne (0b001110).
- div a=13,b=4: in_ready=0 during DIV. out_valid exactly 5 edges after accept, res[3:0]=3, err=0. With ARITH_SEQ_REM_EN: res[7:4]=1, else 0.
- div a=7,b=0 -> latency 1, res[3:0]=0xF, err=0b01. With ARITH_SEQ_REM_EN: res[7:4]=7. Then op=12 -> res=0, err=0b10.
- Backpressure: out_ready=0 for 3 cycles after an xor result (a=0xA,b=0x6). res=0x0C held stable, in_ready=0, a request presented meanwhile is not accepted. out_ready=1 -> out_valid drops next edge, request accepted the cycle after.
- Reset mid-division: assert rst_n=0 at cycle 2 of DIV, asynchronously between edges. Outputs reach reset values immediately. After release no out_valid appears, and the next add 1+1 returns res=0x02.
